shift_reg_univ: RTL and testbench

Parametrised universal shift register: serial-in/serial-out/parallel-in/parallel-out, with left and right shift, parallel load, and a word-completion counter. It is the general-purpose successor to the team's fixed 3-bit serial-in register. It sits between bit-serial links and word-wide datapaths, both as a deserialiser and as a serialiser. The `word_done` pulse tells downstream logic that a full word has been shifted.

---
 rtl/shreg_pkg.sv | 12 +
 rtl/shreg_bitcnt.sv | 41 ++++
 rtl/shift_reg_univ.sv | 88 ++++++++
 tb/tb_shift_reg_univ.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/shreg_pkg.sv
// Shared definitions for the universal shift register: mode encodings and mode type.
// Optional feature macro used by the slice: SHREG_ROTATE_EN.
package shreg_pkg;

    typedef enum logic [1:0] {
        SHREG_HOLD = 2'b00,
        SHREG_SHL  = 2'b01,
        SHREG_SHR  = 2'b10,
        SHREG_LOAD = 2'b11
    } shreg_mode_e;

endpackage

// File: rtl/shreg_bitcnt.sv
// Modulo-WIDTH shift counter; wrap pulses for one cycle after the counter rolls over.
module shreg_bitcnt #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     inc,
    input  logic                     clr,
    output logic [$clog2(WIDTH)-1:0] cnt,
    output logic                     wrap
);

    localparam int unsigned CW = $clog2(WIDTH);

    logic [CW-1:0] r_cnt;
    logic          r_wrap;

    // clr has priority so a load on the final shift position never reports a word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            if (clr) begin
                r_cnt <= '0;
            end else if (inc) begin
                if (r_cnt == CW'(WIDTH - 1)) begin
                    r_cnt  <= '0;
                    r_wrap <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign cnt  = r_cnt;
    assign wrap = r_wrap;

endmodule

// File: rtl/shift_reg_univ.sv
// Universal shift register: hold / shift left / shift right / parallel load with word counter.
// Rotate support (rot port) is built only when SHREG_ROTATE_EN is defined.
module shift_reg_univ
    import shreg_pkg::*;
#(
    parameter int unsigned      WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [1:0]               mode,
    input  logic                     sin_l,
    input  logic                     sin_r,
    input  logic [WIDTH-1:0]         pdata,
`ifdef SHREG_ROTATE_EN
    input  logic                     rot,
`endif
    output logic [WIDTH-1:0]         q,
    output logic                     sout_l,
    output logic                     sout_r,
    output logic [$clog2(WIDTH)-1:0] cnt,
    output logic                     word_done
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_next;
    logic             w_sin_l;
    logic             w_sin_r;
    logic             w_inc;
    logic             w_clr;
    shreg_mode_e      w_mode;

    assign w_mode = shreg_mode_e'(mode);

    always_comb begin
        w_sin_l = sin_l;
        w_sin_r = sin_r;
`ifdef SHREG_ROTATE_EN
        if (rot) begin
            w_sin_l = r_q[WIDTH-1];
            w_sin_r = r_q[0];
        end
`endif
    end

    always_comb begin
        w_q_next = r_q;
        w_inc    = 1'b0;
        w_clr    = 1'b0;
        if (en) begin
            case (w_mode)
                SHREG_SHL: begin
                    w_q_next = {r_q[WIDTH-2:0], w_sin_l};
                    w_inc    = 1'b1;
                end
                SHREG_SHR: begin
                    w_q_next = {w_sin_r, r_q[WIDTH-1:1]};
                    w_inc    = 1'b1;
                end
                SHREG_LOAD: begin
                    w_q_next = pdata;
                    w_clr    = 1'b1;
                end
                default: w_q_next = r_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_q <= RST_VAL;
        else     r_q <= w_q_next;
    end

    shreg_bitcnt #(.WIDTH(WIDTH)) u_bitcnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (w_inc),
        .clr  (w_clr),
        .cnt  (cnt),
        .wrap (word_done)
    );

    assign q      = r_q;
    assign sout_l = r_q[WIDTH-1];
    assign sout_r = r_q[0];

endmodule

// File: tb/tb_shift_reg_univ.sv
// Directed self-checking bench for shift_reg_univ (WIDTH=8, RST_VAL=0).
`timescale 1ns/1ps
module tb_shift_reg_univ;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic       sin_l;
    logic       sin_r;
    logic [7:0] pdata;
    logic       rot;
    logic [7:0] q;
    logic       sout_l;
    logic       sout_r;
    logic [2:0] cnt;
    logic       word_done;

    int unsigned n_cmp = 0;
    int unsigned n_mis = 0;

    shift_reg_univ #(.WIDTH(8), .RST_VAL(8'h00)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .mode      (mode),
        .sin_l     (sin_l),
        .sin_r     (sin_r),
        .pdata     (pdata),
`ifdef SHREG_ROTATE_EN
        .rot       (rot),
`endif
        .q         (q),
        .sout_l    (sout_l),
        .sout_r    (sout_r),
        .cnt       (cnt),
        .word_done (word_done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, then sample 1ns after the rising edge.
    task automatic step(input logic e, input logic [1:0] m, input logic sl, input logic sr,
                        input logic [7:0] pd, input logic r);
        en    = e;
        mode  = m;
        sin_l = sl;
        sin_r = sr;
        pdata = pd;
        rot   = r;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_rst();
        #2 rst = 1'b1;
        #1;
    endtask

    logic [7:0] des_bits;
    logic [7:0] exp_q;
    int unsigned n_en;

    initial begin
        rst = 1'b1; en = 1'b0; mode = 2'b00; sin_l = 1'b0; sin_r = 1'b0;
        pdata = 8'h00; rot = 1'b0;
        #12;
        check_eq("rst_q", q, 8'h00);
        check_eq("rst_cnt", cnt, 0);
        check_eq("rst_wd", word_done, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Reset mid-word, asynchronous
        step(1, 2'b11, 0, 0, 8'hFF, 0);
        check_eq("load_ff", q, 8'hFF);
        step(1, 2'b01, 0, 0, 8'h00, 0);
        step(1, 2'b01, 0, 0, 8'h00, 0);
        check_eq("pre_rst_q", q, 8'hFC);
        check_eq("pre_rst_cnt", cnt, 2);
        pulse_rst();
        check_eq("async_rst_q", q, 8'h00);
        check_eq("async_rst_cnt", cnt, 0);
        check_eq("async_rst_wd", word_done, 0);
        rst = 1'b0;

        // Deserialise 1,0,1,1,0,0,1,0 -> B2
        des_bits = 8'b1011_0010;
        for (int i = 0; i < 8; i++) begin
            step(1, 2'b01, des_bits[7-i], 0, 8'h00, 0);
            if (i < 7) begin
                check_eq("des_wd_low", word_done, 0);
                check_eq("des_cnt", cnt, i + 1);
            end
        end
        check_eq("des_q", q, 8'hB2);
        check_eq("des_wd", word_done, 1);
        check_eq("des_cnt_wrap", cnt, 0);
        step(1, 2'b00, 1, 1, 8'h55, 0);
        check_eq("hold_wd_clear", word_done, 0);
        check_eq("hold_q", q, 8'hB2);

        // Serialise A5 right with sin_r=0
        step(1, 2'b11, 0, 0, 8'hA5, 0);
        check_eq("ser_sout_r0", sout_r, 1);
        check_eq("ser_sout_l", sout_l, 1);
        step(1, 2'b10, 0, 0, 8'h00, 0);
        check_eq("ser_q1", q, 8'h52);
        check_eq("ser_sout_r1", sout_r, 0);
        step(1, 2'b10, 0, 0, 8'h00, 0);
        check_eq("ser_sout_r2", sout_r, 1);
        step(1, 2'b10, 0, 0, 8'h00, 0);
        check_eq("ser_q3", q, 8'h14);
        check_eq("ser_sout_r3", sout_r, 0);
        check_eq("ser_cnt", cnt, 3);

        // Enable gating; disabled cycles present a load that must be ignored
        step(1, 2'b11, 0, 0, 8'h00, 0);
        exp_q = 8'h00;
        n_en  = 0;
        for (int i = 0; i < 16; i++) begin
            if (i % 2 == 0) begin
                step(1, 2'b01, 1, 0, 8'hAA, 0);
                exp_q = {exp_q[6:0], 1'b1};
                n_en++;
            end else begin
                step(0, 2'b11, 0, 0, 8'hAA, 0);
            end
            check_eq("gate_q", q, exp_q);
            check_eq("gate_wd", word_done, (i == 14) ? 1 : 0);
            check_eq("gate_cnt", cnt, n_en % 8);
        end

        // Load mid-word, then load on the wrap position
        step(1, 2'b11, 0, 0, 8'h00, 0);
        for (int i = 0; i < 5; i++) step(1, 2'b01, 0, 0, 8'h00, 0);
        check_eq("mid_cnt5", cnt, 5);
        step(1, 2'b11, 0, 0, 8'h3C, 0);
        check_eq("mid_load_q", q, 8'h3C);
        check_eq("mid_load_cnt", cnt, 0);
        for (int i = 0; i < 7; i++) begin
            step(1, 2'b01, 0, 0, 8'h00, 0);
            check_eq("mid_wd_low", word_done, 0);
        end
        check_eq("mid_cnt7", cnt, 7);
        step(1, 2'b11, 0, 0, 8'h5A, 0);
        check_eq("wrap_load_q", q, 8'h5A);
        check_eq("wrap_load_cnt", cnt, 0);
        check_eq("wrap_load_wd", word_done, 0);

        // Mixed directions count together: 4 left then 4 right
        for (int i = 0; i < 4; i++) step(1, 2'b01, 1, 0, 8'h00, 0);
        check_eq("mix_q_left", q, 8'hAF);
        for (int i = 0; i < 3; i++) step(1, 2'b10, 0, 0, 8'h00, 0);
        check_eq("mix_wd_low", word_done, 0);
        step(1, 2'b10, 0, 0, 8'h00, 0);
        check_eq("mix_q", q, 8'h0A);
        check_eq("mix_wd", word_done, 1);

        // Reset cuts the pulse short
        pulse_rst();
        check_eq("rst_cut_wd", word_done, 0);
        check_eq("rst_cut_q", q, 8'h00);
        rst = 1'b0;

`ifdef SHREG_ROTATE_EN
        step(1, 2'b11, 0, 0, 8'h81, 0);
        step(1, 2'b01, 0, 0, 8'h00, 1);
        check_eq("rot_q1", q, 8'h03);
        for (int i = 0; i < 7; i++) step(1, 2'b01, 0, 0, 8'h00, 1);
        check_eq("rot_q8", q, 8'h81);
        check_eq("rot_wd", word_done, 1);
        step(1, 2'b10, 0, 0, 8'h00, 1);
        check_eq("rot_r_q", q, 8'hC0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
